// File: rtl/nor_result_scoreboard.sv
// Per-cycle checker for a 2-input NOR stage: counts samples, mismatches and the
// longest mismatch run over an N_SAMPLES window, and latches the first bad index.
module nor_result_scoreboard #(
  parameter int CNT_W     = 16,
  parameter int N_SAMPLES = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             out_ref,
  input  logic             out_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] max_run,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_RUN   = 2'd1;
  localparam logic [1:0]       ST_DONE  = 2'd2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] run_len;
  logic             miss_p0;
  logic [CNT_W-1:0] cnt_next_p0;
  logic [CNT_W-1:0] err_next_p0;
  logic [CNT_W-1:0] run_next_p0;

  function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // p0: compare the incoming pair and form next counter values
  always_comb begin
    miss_p0     = out_ref ^ out_dut;
    cnt_next_p0 = sample_count + CNT_W'(1);
    err_next_p0 = err_count + CNT_W'(miss_p0);
    run_next_p0 = miss_p0 ? (run_len + CNT_W'(1)) : '0;
  end

  // p1: registered state and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mismatch        <= 1'b0;
      first_err_valid <= 1'b0;
      sample_count    <= '0;
      err_count       <= '0;
      max_run         <= '0;
      first_err_idx   <= '0;
      run_len         <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (abort) begin
            // Abort drops this edge's sample and leaves counts readable in IDLE
            state    <= ST_IDLE;
            busy     <= 1'b0;
            mismatch <= 1'b0;
          end else begin
            sample_count <= cnt_next_p0;
            err_count    <= err_next_p0;
            run_len      <= run_next_p0;
            max_run      <= umax(max_run, run_next_p0);
            mismatch     <= miss_p0;
            if (miss_p0 && !first_err_valid) begin
              first_err_idx   <= sample_count;
              first_err_valid <= 1'b1;
            end
            if (cnt_next_p0 == LAST_CNT) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next_p0 == '0);
            end
          end
        end
        default: begin
          mismatch <= 1'b0;
          if (start) begin
            state           <= ST_RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            sample_count    <= '0;
            err_count       <= '0;
            max_run         <= '0;
            first_err_idx   <= '0;
            run_len         <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/nor_result_scoreboard.md
# nor_result_scoreboard

Synthesizable per-cycle result checker that sits directly downstream of the 2-input NOR stage (`out = ~(in1 | in2)`). It consumes the golden output and the device-under-test output on every rising clock edge during a measurement window of `N_SAMPLES` cycles. It accumulates sample, mismatch and longest-mismatch-run counts, and latches the index of the first mismatch. It reports a pass/fail verdict when the window closes, so the NOR comparison can run on silicon or emulation without a simulator-side checker.

## Interface
Parameters:
- `CNT_W`, default 16: width of all counters and index outputs.
- `N_SAMPLES`, default 200: samples per window. Legal range is 1 to 2^CNT_W−1; outside that range, behaviour is undefined.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: opens a measurement window. Honoured only in IDLE or DONE.
- `abort`  in  1: ends the window early. Honoured only in RUN.
- `out_ref`  in  1: golden NOR output.
- `out_dut`  in  1: NOR output under test.
- `busy`  out  1: high while in RUN.
- `done`  out  1: high while in DONE.
- `pass`  out  1: `done && (err_count == 0)`, registered.
- `mismatch`  out  1: registered `out_ref != out_dut` for the most recent RUN sample. Cleared outside RUN.
- `sample_count`  out  CNT_W: number of samples taken in the current or last window.
- `err_count`  out  CNT_W: number of mismatching samples.
- `max_run`  out  CNT_W: longest run of consecutive mismatching samples.
- `first_err_idx`  out  CNT_W: 0-based sample index of the first mismatch.
- `first_err_valid`  out  1: `first_err_idx` holds a valid index.

## Operation
State machine with three states: IDLE, RUN, DONE.

IDLE:
- `start=1` → all counters, `first_err_*`, `mismatch` and the internal current-run counter are cleared; next state is RUN.
- `abort` is ignored.

RUN: on every edge, take one sample. Index `i` is the `sample_count` value before increment.
- `sample_count` increments by 1.
- `mismatch` is set to `out_ref != out_dut`.
- On a mismatch:
  - `err_count` increments by 1.
  - The current-run counter increments by 1.
  - `max_run` is updated to max(`max_run`, new run value) in the same edge.
  - If `first_err_valid=0`: `first_err_idx` ← `i` and `first_err_valid` ← 1.
- On a match: the current-run counter is cleared.
- The sample for which the new `sample_count` equals `N_SAMPLES` is the last sample; next state is DONE.
- `abort=1` → next state is IDLE, and that edge's sample is NOT taken. Counters hold their values, `mismatch` is cleared, `done` and `pass` stay 0.
- `abort` and last-sample on the same edge: `abort` wins.
- `start` is ignored in RUN, including when asserted together with `abort`.

DONE:
- Counters hold.
- `pass` reflects the verdict.
- `start=1` → clear exactly as from IDLE and go to RUN; `done` and `pass` drop on that edge.

Arithmetic rules:
- No counter can overflow, because `N_SAMPLES` ≤ 2^CNT_W−1 and every count is ≤ `sample_count`.
- Comparison is strictly 2-state. X/Z on the inputs is outside this block's scope.

## Timing
- Reset (synchronous, takes priority over everything): state IDLE; `busy`, `done`, `pass`, `mismatch`, `first_err_valid` = 0; all CNT_W outputs = 0.
- `start` sampled at edge E0: `busy`=1 after E0. The first sample is taken at E1 using inputs present just before E1.
- Samples are taken at E1 through E(N_SAMPLES).
- After E(N_SAMPLES): `busy`=0, `done`=1, and `pass` is valid in the same cycle.
- Latency: `start` to `done` = `N_SAMPLES`+1 edges.
- Every output is registered. There is no combinational path from any input to any output.
- Back-to-back windows: `start` held high in DONE restarts immediately, with one DONE cycle between windows.
- `reset` asserted mid-RUN: returns to IDLE at that edge with all outputs cleared, regardless of `start`/`abort`.

## Test plan
- **All-match run:** reset, then `start` for 1 cycle, then drive `out_ref = out_dut` = NOR of random `in1`/`in2` for 200 cycles.
  - Required: `done`=1 exactly 201 edges after `start`; `pass`=1; `sample_count`=200; `err_count`=0; `first_err_valid`=0; `max_run`=0.
- **Isolated and clustered errors:** invert `out_dut` at sample indices 7, 50, 51 and 52 only.
  - Required: `err_count`=4; `first_err_idx`=7; `max_run`=3; `pass`=0; `mismatch` pulses high for the cycle after each erroneous sample.
- **Abort mid-window:** `abort` at the edge that would take sample 100, with errors at indices 10 and 11.
  - Required: state IDLE; `sample_count`=100; `err_count`=2; `done`=0; `pass`=0.
  - Then `start` → all counters read 0 on the next cycle.
- **Edge collisions:**
  - `abort` asserted on the final-sample edge → IDLE with `sample_count`=199, `done`=0.
  - `start` pulsed during RUN at sample 20 → ignored; window still ends at 200.
- **Reset mid-RUN:** assert `reset` at sample 50 with `start` also high.
  - Required: all outputs 0, state IDLE, no restart.
  - Then `start` → a fresh window completes normally.
- **Boundary parameters:**
  - `N_SAMPLES`=1 with a mismatch → `done` 2 edges after `start`; `err_count`=1, `first_err_idx`=0, `max_run`=1.
  - `CNT_W`=4, `N_SAMPLES`=15, all mismatching → `err_count`=15, `max_run`=15, no wrap.
